// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns pipeline requests into byte-enabled word
// transactions, splitting boundary-crossing accesses and realigning load data.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter bit          SPLIT_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic [2:0]  reqBytes;
    logic [2:0]  reqEnd;
    logic [32:0] reqLast;
    logic        reqSpan;
    logic        reqErr;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   reqBytes = 3'd1;
            2'b01:   reqBytes = 3'd2;
            default: reqBytes = 3'd4;
        endcase
    end

    // Legality is decided once at acceptance; the 33-bit sum catches address wrap.
    assign reqEnd  = {1'b0, req_addr[1:0]} + reqBytes;
    assign reqSpan = (reqEnd > 3'd4);
    assign reqLast = {1'b0, req_addr} + {30'd0, reqBytes} - 33'd1;
    assign reqErr  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]) ||
                     (reqLast >= 33'(MEM_BYTES)) ||
                     (reqSpan && !SPLIT_EN);

    logic [1:0]  addrOff;
    logic [3:0]  byteMask;
    logic [7:0]  laneMask;
    logic [63:0] wideWdata;
    logic [31:0] rawWord;
    logic [31:0] loadData;
    logic        signExt;
    logic        spanQ;

    assign addrOff = addr_q[1:0];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   byteMask = 4'b0001;
            2'b01:   byteMask = 4'b0011;
            default: byteMask = 4'b1111;
        endcase
    end

    // Upper nibble / word of the shifted mask and data feed the second transaction.
    assign laneMask  = {4'b0000, byteMask} << addrOff;
    assign wideWdata = {32'd0, wdata_q} << {addrOff, 3'b000};
    assign spanQ     = (laneMask[7:4] != 4'b0000);
    assign rawWord   = 32'({hi_q, lo_q} >> {addrOff, 3'b000});
    assign signExt   = ~funct3_q[2];

    always_comb begin
        case (funct3_q[1:0])
            2'b00:   loadData = {{24{signExt & rawWord[7]}}, rawWord[7:0]};
            2'b01:   loadData = {{16{signExt & rawWord[15]}}, rawWord[15:0]};
            default: loadData = rawWord;
        endcase
    end

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        we_d       = we_q;
        err_d      = err_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    err_d    = reqErr;
                    lo_d     = 32'd0;
                    hi_d     = 32'd0;
                    state_d  = reqErr ? RESP : ISSUE0;
                end
            end
            ISSUE0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = laneMask[3:0];
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wideWdata[31:0];
                if (mem_gnt) state_d = WAIT0;
            end
            WAIT0: begin
                if (mem_rvalid) begin
                    lo_d    = mem_rdata;
                    state_d = spanQ ? ISSUE1 : RESP;
                end
            end
            ISSUE1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = laneMask[7:4];
                mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem_wdata = wideWdata[63:32];
                if (mem_gnt) state_d = WAIT1;
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    hi_d    = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'd0 : loadData;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= 32'd0;
            hi_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            err_q    <= err_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory responder that
// supports grant stalls and holding back read-valid.
module tb_load_store_unit;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid2, req_ready2, resp_valid2, resp_err2;
    logic [31:0] resp_rdata2;
    logic        mem_req2, mem_we2;
    logic [3:0]  mem_be2;
    logic [31:0] mem_addr2, mem_wdata2;
    logic        tieLow;
    logic [31:0] tieWord;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] txnAddr[$];
    logic [31:0] txnWdata[$];
    logic [3:0]  txnBe[$];
    logic        txnWe[$];
    int          txnCount = 0;
    int          stallCycles;
    int          stallUsed = 0;
    logic        rvalidHold;
    logic        pendValid = 1'b0;
    logic [31:0] pendData = 32'd0;

    load_store_unit #(.MEM_BYTES(4096), .SPLIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MEM_BYTES(4096), .SPLIT_EN(1'b0)) dutNoSplit (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_be(mem_be2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_gnt(tieLow), .mem_rvalid(tieLow),
        .mem_rdata(tieWord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: grants after stallCycles, returns rvalid one cycle later.
    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        if (pendValid && !rvalidHold) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pendData;
            pendValid  = 1'b0;
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
            if (stallUsed < stallCycles) begin
                stallUsed++;
            end else begin
                mem_gnt   = 1'b1;
                stallUsed = 0;
                txnAddr.push_back(mem_addr);
                txnWdata.push_back(mem_wdata);
                txnBe.push_back(mem_be);
                txnWe.push_back(mem_we);
                txnCount++;
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    pendData = 32'd0;
                end else begin
                    pendData = mem[mem_addr[11:2]];
                end
                pendValid = 1'b1;
            end
        end else begin
            stallUsed = 0;
        end
    end

    task automatic doAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({mem_req, mem_we, mem_be, resp_valid, resp_err, req_ready} !== 9'b0_0_0000_0_0_1) begin errors++; $display("FAIL reset_ctrl: got %b expected %b", {mem_req, mem_we, mem_be, resp_valid, resp_err, req_ready}, 9'b0_0_0000_0_0_1); end
        checks++; if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, resp_rdata}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_load();
        logic [31:0] rd; logic er; int lat; int base;
        base = txnCount;
        doAccess(1'b0, 3'b000, 32'h103, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFF88) begin errors++; $display("FAIL lb_103_data: got %h expected %h", rd, 32'hFFFFFF88); end
        checks++; if ({er, lat} !== {1'b0, 32'd3}) begin errors++; $display("FAIL lb_103_err_lat: got err=%b lat=%0d expected err=0 lat=3", er, lat); end
        checks++; if (txnCount !== base + 1) begin errors++; $display("FAIL lb_103_txn_count: got %0d expected %0d", txnCount - base, 1); end
        checks++; if ({txnAddr[base], txnBe[base], txnWe[base]} !== {32'h100, 4'b1000, 1'b0}) begin errors++; $display("FAIL lb_103_txn: got addr=%h be=%b expected addr=00000100 be=1000", txnAddr[base], txnBe[base]); end
    endtask

    task automatic test_split_load();
        logic [31:0] rd; logic er; int lat; int base;
        base = txnCount;
        doAccess(1'b0, 3'b010, 32'h101, 32'd0, rd, er, lat);
        checks++; if ({rd, er} !== {32'h448899AA, 1'b0}) begin errors++; $display("FAIL lw_101_data: got %h err=%b expected 448899aa err=0", rd, er); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL lw_101_latency: got %0d expected 5", lat); end
        checks++; if ({txnAddr[base], txnBe[base], txnAddr[base+1], txnBe[base+1]} !== {32'h100, 4'b1110, 32'h104, 4'b0001}) begin errors++; $display("FAIL lw_101_txns: got %h/%b %h/%b expected 00000100/1110 00000104/0001", txnAddr[base], txnBe[base], txnAddr[base+1], txnBe[base+1]); end
        doAccess(1'b0, 3'b001, 32'h102, 32'd0, rd, er, lat);
        checks++; if ({rd, lat} !== {32'hFFFF8899, 32'd3}) begin errors++; $display("FAIL lh_102: got %h lat=%0d expected ffff8899 lat=3", rd, lat); end
        doAccess(1'b0, 3'b101, 32'h103, 32'd0, rd, er, lat);
        checks++; if ({rd, lat} !== {32'h00004488, 32'd5}) begin errors++; $display("FAIL lhu_103: got %h lat=%0d expected 00004488 lat=5", rd, lat); end
    endtask

    task automatic test_split_store();
        logic [31:0] rd; logic er; int lat; int base;
        base = txnCount;
        doAccess(1'b1, 3'b010, 32'h102, 32'hDEADBEEF, rd, er, lat);
        checks++; if ({rd, er, lat} !== {32'd0, 1'b0, 32'd5}) begin errors++; $display("FAIL sw_102_resp: got %h err=%b lat=%0d expected 0 err=0 lat=5", rd, er, lat); end
        checks++; if ({txnWe[base], txnAddr[base], txnBe[base], txnWdata[base]} !== {1'b1, 32'h100, 4'b1100, 32'hBEEF0000}) begin errors++; $display("FAIL sw_102_txn0: got we=%b %h %b %h expected we=1 00000100 1100 beef0000", txnWe[base], txnAddr[base], txnBe[base], txnWdata[base]); end
        checks++; if ({txnWe[base+1], txnAddr[base+1], txnBe[base+1], txnWdata[base+1]} !== {1'b1, 32'h104, 4'b0011, 32'h0000DEAD}) begin errors++; $display("FAIL sw_102_txn1: got we=%b %h %b %h expected we=1 00000104 0011 0000dead", txnWe[base+1], txnAddr[base+1], txnBe[base+1], txnWdata[base+1]); end
        doAccess(1'b0, 3'b010, 32'h100, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'hBEEFAABB) begin errors++; $display("FAIL lw_100_readback: got %h expected beefaabb", rd); end
        base = txnCount;
        doAccess(1'b1, 3'b000, 32'h105, 32'h1234565A, rd, er, lat);
        checks++; if ({txnAddr[base], txnBe[base], txnWdata[base]} !== {32'h104, 4'b0010, 32'h34565A00}) begin errors++; $display("FAIL sb_105_txn: got %h %b %h expected 00000104 0010 34565a00", txnAddr[base], txnBe[base], txnWdata[base]); end
        doAccess(1'b0, 3'b100, 32'h105, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h0000005A) begin errors++; $display("FAIL lbu_105: got %h expected 0000005a", rd); end
        doAccess(1'b0, 3'b000, 32'h107, 32'd0, rd, er, lat);
        checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lb_107: got %h expected 00000011", rd); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; int lat; int base;
        base = txnCount;
        stallCycles = 5;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'd0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h104, 32'h0}) begin errors++; $display("FAIL stall_hold_%0d: got req=%b we=%b be=%b %h %h", c, mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
            checks++; if ({req_ready, resp_valid} !== 2'b00) begin errors++; $display("FAIL stall_ready_%0d: got ready=%b resp=%b expected 0 0", c, req_ready, resp_valid); end
        end
        lat = -1; rd = 32'd0;
        for (int c = 6; c <= 40; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rd = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
        stallCycles = 0;
        checks++; if ({rd, lat} !== {32'h11225AAD, 32'd8}) begin errors++; $display("FAIL stall_resp: got %h lat=%0d expected 11225aad lat=8", rd, lat); end
        repeat (3) @(negedge clk);
        checks++; if ({txnCount - base, req_ready, resp_valid} !== {32'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL stall_no_reaccept: got txns=%0d ready=%b resp=%b expected 1 1 0", txnCount - base, req_ready, resp_valid); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; int base;
        base = txnCount;
        doAccess(1'b0, 3'b011, 32'h100, 32'd0, rd, er, lat);
        checks++; if ({er, rd, lat} !== {1'b1, 32'd0, 32'd1}) begin errors++; $display("FAIL err_funct3_011: got err=%b %h lat=%0d expected err=1 0 lat=1", er, rd, lat); end
        @(negedge clk);
        checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin errors++; $display("FAIL err_resp_clear: got %b %b %h expected 0 0 0", resp_valid, resp_err, resp_rdata); end
        doAccess(1'b1, 3'b100, 32'h100, 32'h55, rd, er, lat);
        checks++; if ({er, lat} !== {1'b1, 32'd1}) begin errors++; $display("FAIL err_sbu: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
        doAccess(1'b0, 3'b010, 32'hFFE, 32'd0, rd, er, lat);
        checks++; if ({er, lat} !== {1'b1, 32'd1}) begin errors++; $display("FAIL err_lw_ffe: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
        doAccess(1'b0, 3'b000, 32'h1000, 32'd0, rd, er, lat);
        checks++; if ({er, lat} !== {1'b1, 32'd1}) begin errors++; $display("FAIL err_lb_1000: got err=%b lat=%0d expected err=1 lat=1", er, lat); end
        doAccess(1'b0, 3'b010, 32'hFFC, 32'd0, rd, er, lat);
        checks++; if ({er, rd, lat} !== {1'b0, 32'd0, 32'd3}) begin errors++; $display("FAIL ok_lw_ffc: got err=%b %h lat=%0d expected err=0 0 lat=3", er, rd, lat); end
        checks++; if (txnCount - base !== 1) begin errors++; $display("FAIL err_no_mem_txn: got %0d expected 1", txnCount - base); end
        @(negedge clk);
        req_valid2 = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
        @(posedge clk);
        #1 req_valid2 = 1'b0;
        @(negedge clk);
        checks++; if ({resp_valid2, resp_err2, mem_req2, resp_rdata2} !== {1'b1, 1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL nosplit_lw_101: got v=%b err=%b req=%b %h expected 1 1 0 0", resp_valid2, resp_err2, mem_req2, resp_rdata2); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int base; int seen;
        base = txnCount;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h101;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (txnCount == base + 2) begin
                rvalidHold = 1'b1;
                break;
            end
        end
        checks++; if (txnCount - base !== 2) begin errors++; $display("FAIL rst_mid_reach_wait1: got %0d txns expected 2", txnCount - base); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, resp_valid, req_ready, mem_be, mem_addr} !== {1'b0, 1'b0, 1'b1, 4'd0, 32'd0}) begin errors++; $display("FAIL rst_mid_outputs: got req=%b resp=%b ready=%b be=%b %h", mem_req, resp_valid, req_ready, mem_be, mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        rvalidHold = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_req) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stray_rvalid: got %0d active cycles expected 0", seen); end
        doAccess(1'b0, 3'b000, 32'h100, 32'd0, rd, er, lat);
        checks++; if ({rd, er, lat} !== {32'hFFFFFFBB, 1'b0, 32'd3}) begin errors++; $display("FAIL rst_then_lb: got %h err=%b lat=%0d expected ffffffbb err=0 lat=3", rd, er, lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_valid2 = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tieLow = 1'b0; tieWord = 32'd0;
        stallCycles = 0; rvalidHold = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[32'h100 >> 2] = 32'h8899AABB;
        mem[32'h104 >> 2] = 32'h11223344;
        test_reset();
        test_aligned_load();
        test_split_load();
        test_split_store();
        test_stall();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage initiator that turns pipeline load/store requests into transactions on a 32-bit word-organised, byte-enabled data memory port.
- Byte, halfword and word accesses use the same 3-bit size/sign encoding as the data memory's dm_control: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Misaligned accesses that cross a word boundary are split into two word transactions. Load data is realigned and sign/zero-extended before it is returned.
- One request is in flight at a time.

Parameters:
MEM_BYTES, 4096, size of the data memory in bytes; an access touching any byte at or above MEM_BYTES is an error.
SPLIT_EN, 1, 1 = split boundary-crossing accesses into two transactions; 0 = flag them as errors.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request valid
req_ready  out  1  unit idle and able to accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  access size/sign, dm_control encoding
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3 or address, qualified by resp_valid
mem_req  out  1  memory transaction request
mem_we  out  1  transaction is a write
mem_be  out  4  byte enables
mem_addr  out  32  word address, bits [1:0] always 0
mem_wdata  out  32  lane-aligned write data
mem_gnt  in  1  memory accepted the transaction this cycle
mem_rvalid  in  1  transaction complete; read data or write ack
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_valid, resp_rdata and resp_err are all 0. req_ready=1, since it is decoded from state==IDLE.
- Reset mid-operation: the in-flight access is abandoned, mem_req drops immediately and no response is issued. Any later mem_rvalid from the abandoned access is ignored in IDLE.
- Accept: a request is taken on req_valid && req_ready. At acceptance, latch addr, we, funct3 and wdata, and compute:
  - n = 1/2/4 bytes
  - off = addr[1:0]
  - span = (off+n > 4)
- Errors, checked at acceptance. Any one makes the access illegal:
  - funct3 is 011, 110 or 111;
  - a store with funct3[2]=1;
  - addr+n-1 >= MEM_BYTES, computed in 33 bits;
  - span && !SPLIT_EN.
- An illegal access goes IDLE→RESP with resp_err=1, resp_rdata=0 and no memory transaction.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE→ISSUE0 on accept of a legal access.
  - ISSUEx: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_gnt; on mem_gnt go to WAITx. In the grant cycle mem_req is still high; it is 0 from the next cycle.
  - WAIT0: on mem_rvalid, capture mem_rdata into lo, then go to ISSUE1 if span, else RESP.
  - WAIT1: on mem_rvalid, capture into hi, then go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. Response outputs return to 0 when resp_valid is low.
- Transaction 0:
  - mem_addr = addr & ~3
  - mem_be = ((1<<n)-1)<<off, truncated to 4 bits
  - mem_wdata = wdata<<(8*off)
- Transaction 1 (span only):
  - mem_addr = (addr & ~3)+4
  - mem_be = ((1<<n)-1)>>(4-off)
  - mem_wdata = wdata>>(8*(4-off))
- Read assembly: the 64-bit value {hi,lo} (hi=0 if no span) is shifted right by 8*off and the low n bytes are kept. Those bytes are sign-extended when funct3[2]=0, zero-extended when funct3[2]=1. Little-endian byte order.
- Stores: still wait for mem_rvalid as a write ack; resp_rdata=0.
- Latency, best case (gnt in the issue cycle, rvalid the next cycle), counting the accept edge as cycle 0:
  - aligned access: resp_valid in cycle 3;
  - split access: resp_valid in cycle 5;
  - error: resp_valid in cycle 1.
- Stalls: mem_rvalid while in ISSUEx or IDLE is ignored. mem_gnt has no effect outside ISSUEx.

Test Plan:
1. Memory words 0x100=0x8899AABB, 0x104=0x11223344; LB at 0x103 → one transaction, mem_addr 0x100, be 1000; resp_rdata 0xFFFFFF88, resp_err 0.
2. LW at 0x101 → two transactions (0x100 be 1110, then 0x104 be 0001); resp_rdata 0x448899AA. LH 0x102 → 0xFFFF8899. LHU 0x103 → 0x00004488.
3. SW 0xDEADBEEF at 0x102 → write 0x100 be 1100 wdata 0xBEEF0000, then 0x104 be 0011 wdata 0x0000DEAD. Reading back LW 0x100 gives 0xBEEFAABB.
4. mem_gnt held low 5 cycles during ISSUE0 → mem_req and all mem_* outputs stable, req_ready 0, no resp_valid until rvalid; req_valid held high is not re-accepted.
5. funct3=011 → resp_valid with resp_err=1 one cycle after accept, no mem_req. SB funct3=100 → error. LW at 0xFFE → error. With SPLIT_EN=0, LW 0x101 → error.
6. Assert rst_n low during WAIT1 of a split load → mem_req=0 and resp_valid=0 immediately, req_ready=1. A stray mem_rvalid after reset produces no response, and the next LB completes normally.
